// File: rtl/timer_irq_source.sv
// rtl/timer_irq_source.sv - countdown timer with one-shot/auto-reload IRQ source
// Optional TIMER_PRESCALE_EN adds a 4-bit prescaler configured through CTRL[7:4].
module timer_irq_source #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

    state_t           state_q, state_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             en, auto_reload, tick;
    logic             unused_wdata;

    assign en           = ctrl_q[0];
    assign auto_reload  = (ctrl_q[2:1] == 2'b01);
    assign unused_wdata = ^wdata;

`ifdef TIMER_PRESCALE_EN
    logic [3:0] ps_cnt_q, ps_cnt_d;

    assign tick = (ps_cnt_q == ctrl_q[7:4]);

    // Prescaler only runs while counting; everywhere else it is held at zero.
    always_comb begin
        ps_cnt_d = 4'd0;
        if (state_q == S_CNT && !tick) begin
            ps_cnt_d = ps_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_cnt_q <= 4'd0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    // COUNT of 0 or 1 both terminate, so PRESET=0 acts like 1.
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d = '0;
                        state_d = S_INT;
                    end
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    state_d = S_LOAD;
                end else begin
                    pending_d = 1'b1;
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes override the FSM's EN clear; any CTRL write acknowledges.
        if (we) begin
            case (addr)
                2'd0: begin
                    ctrl_d    = wdata[7:0] & CTRL_WMASK;
                    pending_d = 1'b0;
                end
                2'd1: preset_d = wdata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ctrl_q    <= 8'd0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata[7:0]       = ctrl_q;
            2'd1: rdata[CNT_W-1:0] = preset_q;
            2'd2: rdata[CNT_W-1:0] = count_q;
            default: ;
        endcase
    end

    assign irq = ctrl_q[3] & (pending_q | (state_q == S_INT));

endmodule

// File: tb/tb_timer_irq_source.sv
// tb/tb_timer_irq_source.sv - directed self-checking bench for timer_irq_source
module tb_timer_irq_source;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int tests  = 0;
    int failed = 0;

    timer_irq_source #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk_irq("rst_irq", 1'b0);
        for (int a = 0; a < 4; a++) begin
            chk_reg($sformatf("rst_rd%0d", a), 2'(a), 32'd0);
        end

        // One-shot, PRESET=5, IM=1
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step();
        chk_reg("os_cnt_e1", 2'd2, 32'd0);
        chk_irq("os_irq_e1", 1'b0);
        for (int k = 2; k <= 7; k++) begin
            step();
            chk_reg($sformatf("os_cnt_e%0d", k), 2'd2, 32'(7 - k));
            chk_irq($sformatf("os_irq_e%0d", k), k == 7);
        end
        step();
        chk_irq("os_irq_held1", 1'b1);
        step();
        chk_irq("os_irq_held2", 1'b1);
        chk_reg("os_ctrl_after", 2'd0, 32'h8);
        wr(2'd0, 32'h8);
        chk_irq("os_ack", 1'b0);

        // Auto-reload, PRESET=3 -> pulse every 5 cycles
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            step();
            chk_irq($sformatf("ar_irq_e%0d", k), (k % 5) == 0);
        end
        chk_reg("ar_ctrl_en", 2'd0, 32'hB);
        wr(2'd0, 32'h0);

        // Mid-count disable freezes COUNT, re-enable reloads PRESET
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step();
        step();
        step();
        wr(2'd0, 32'h8);
        chk_reg("mid_cnt_frozen", 2'd2, 32'd3);
        repeat (3) step();
        chk_reg("mid_cnt_still", 2'd2, 32'd3);
        chk_irq("mid_irq", 1'b0);
        wr(2'd0, 32'h9);
        step();
        step();
        chk_reg("mid_reload", 2'd2, 32'd5);
        wr(2'd1, 32'd2);
        chk_reg("mid_preset_nodisturb", 2'd2, 32'd4);
        wr(2'd0, 32'h0);

        // Masked one-shot: no irq, acknowledge clears pending
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_irq($sformatf("mask_irq_e%0d", k), 1'b0);
        end
        chk_reg("mask_ctrl_enclr", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("mask_ack_irq", 1'b0);
        wr(2'd2, 32'h55);
        chk_reg("count_ro", 2'd2, 32'd0);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_reg("addr3_rd", 2'd3, 32'd0);
        chk_reg("ctrl_keep", 2'd0, 32'h8);
        chk_reg("preset_keep", 2'd1, 32'd1);

        // PRESET=0 behaves as PRESET=1
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step();
        step();
        chk_irq("p0_irq_e2", 1'b0);
        step();
        chk_irq("p0_irq_e3", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("p0_ack", 1'b0);

        // CTRL write on the INT edge: bus value wins, pending cleared
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        step();
        step();
        step();
        chk_irq("col_int", 1'b1);
        wr(2'd0, 32'hB);
        chk_irq("col_irq", 1'b0);
        chk_reg("col_ctrl", 2'd0, 32'hB);
        wr(2'd0, 32'h0);

        // Synchronous reset mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        repeat (4) step();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reg("rr_ctrl", 2'd0, 32'd0);
        chk_reg("rr_preset", 2'd1, 32'd0);
        chk_reg("rr_count", 2'd2, 32'd0);
        chk_irq("rr_irq", 1'b0);
        repeat (3) step();
        chk_reg("rr_count_idle", 2'd2, 32'd0);

`ifdef TIMER_PRESCALE_EN
        // PS=1, PRESET=2 -> INT after 6 edges, COUNT steps every 2nd cycle
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h19);
        step();
        step();
        chk_reg("ps_cnt_e2", 2'd2, 32'd2);
        step();
        chk_reg("ps_cnt_e3", 2'd2, 32'd2);
        step();
        chk_reg("ps_cnt_e4", 2'd2, 32'd1);
        step();
        chk_reg("ps_cnt_e5", 2'd2, 32'd1);
        chk_irq("ps_irq_e5", 1'b0);
        step();
        chk_reg("ps_cnt_e6", 2'd2, 32'd0);
        chk_irq("ps_irq_e6", 1'b1);
        step();
        chk_reg("ps_ctrl_after", 2'd0, 32'h18);
        wr(2'd0, 32'h0);
`else
        wr(2'd0, 32'hF8);
        chk_reg("ps_bits_ignored", 2'd0, 32'h8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
